// File: rtl/zbt_proc_writer.sv
// Write-back stage for processed two-pixel words: buffers words in a small FIFO
// and issues pipelined writes to ZBT bank 1 on arbiter grants.
module zbt_proc_writer #(
    parameter int FIFO_LOGSIZE = 3,
    parameter int ADDR_W       = 19,
    parameter int DATA_W       = 36,
    parameter int V_ACTIVE     = 768
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    pix_valid,
    input  logic [DATA_W-1:0]       proc_pixs,
    input  logic [ADDR_W-1:0]       proc_addr,
    input  logic                    zbt_grant,
    output logic [ADDR_W-1:0]       zbt_addr,
    output logic                    zbt_we,
    output logic [DATA_W-1:0]       zbt_write_data,
    output logic [FIFO_LOGSIZE:0]   fifo_level,
    output logic                    overflow,
    output logic                    idle
);

    localparam int DEPTH   = 1 << FIFO_LOGSIZE;
    localparam int ENTRY_W = ADDR_W + DATA_W;
    localparam int ROW_W   = 10;
    localparam logic [ROW_W-1:0]        V_ROW      = ROW_W'(V_ACTIVE);
    localparam logic [FIFO_LOGSIZE:0]   FULL_LEVEL = (FIFO_LOGSIZE+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [FIFO_LOGSIZE-1:0]   wr_ptr_q, wr_ptr_d;
    logic [FIFO_LOGSIZE-1:0]   rd_ptr_q, rd_ptr_d;
    logic [FIFO_LOGSIZE:0]     level_q, level_d;
    logic                      overflow_q, overflow_d;
    logic                      idle_q, idle_d;
    logic [ADDR_W-1:0]         addr_q, addr_d;
    logic                      we_q, we_d;
    logic [DATA_W-1:0]         wdata_q, wdata_d;
    logic [1:0]                pipe_vld_q, pipe_vld_d;
    logic [1:0][DATA_W-1:0]    pipe_data_q, pipe_data_d;

    logic [ENTRY_W-1:0]        fifo_mem [DEPTH];
    logic [ENTRY_W-1:0]        head;
    logic                      fifo_empty, fifo_full;
    logic                      pop, push_req, push;

    // Head read is combinational so a grant can pop in the same cycle it is seen.
    assign head       = fifo_mem[rd_ptr_q];
    assign fifo_empty = (level_q == '0);
    assign fifo_full  = (level_q == FULL_LEVEL);

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        overflow_d  = overflow_q;
        addr_d      = addr_q;
        we_d        = 1'b0;
        wdata_d     = wdata_q;

        pop      = zbt_grant && !fifo_empty;
        push_req = (state_q == S_RUN) && pix_valid
                   && (proc_addr[ADDR_W-1 -: ROW_W] < V_ROW);
        push     = push_req && (!fifo_full || pop);

        if (push_req && fifo_full && !pop) begin
            overflow_d = 1'b1;
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + FIFO_LOGSIZE'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + FIFO_LOGSIZE'(1);
            addr_d   = head[ENTRY_W-1 -: ADDR_W];
            we_d     = 1'b1;
        end

        if (push && !pop) begin
            level_d = level_q + (FIFO_LOGSIZE+1)'(1);
        end else if (pop && !push) begin
            level_d = level_q - (FIFO_LOGSIZE+1)'(1);
        end

        // Two stages delay the data so it lands two cycles after its write enable.
        pipe_vld_d     = {pipe_vld_q[0], pop};
        pipe_data_d[0] = head[DATA_W-1:0];
        pipe_data_d[1] = pipe_data_q[0];
        if (pipe_vld_q[1]) begin
            wdata_d = pipe_data_q[1];
        end

        case (state_q)
            S_IDLE: begin
                if (enable) state_d = S_RUN;
            end
            S_RUN: begin
                if (!enable) state_d = S_FLUSH;
            end
            S_FLUSH: begin
                if (enable) begin
                    state_d = S_RUN;
                end else if (fifo_empty && !we_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        idle_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            idle_q      <= 1'b1;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            pipe_vld_q  <= '0;
            pipe_data_q <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            overflow_q  <= overflow_d;
            idle_q      <= idle_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            pipe_vld_q  <= pipe_vld_d;
            pipe_data_q <= pipe_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {proc_addr, proc_pixs};
        end
    end

    assign zbt_addr       = addr_q;
    assign zbt_we         = we_q;
    assign zbt_write_data = wdata_q;
    assign fifo_level     = level_q;
    assign overflow       = overflow_q;
    assign idle           = idle_q;

endmodule

// File: tb/tb_zbt_proc_writer.sv
// Bench for zbt_proc_writer: directed and random stimulus checked every cycle
// against a queue-based reference model.
module tb_zbt_proc_writer;

    localparam int LOG = 3;
    localparam int AW  = 19;
    localparam int DW  = 36;
    localparam int VA  = 768;

    logic          clk = 1'b0;
    logic          reset, enable, pix_valid, zbt_grant;
    logic [DW-1:0] proc_pixs;
    logic [AW-1:0] proc_addr;
    logic [AW-1:0] zbt_addr;
    logic          zbt_we;
    logic [DW-1:0] zbt_write_data;
    logic [LOG:0]  fifo_level;
    logic          overflow, idle;

    zbt_proc_writer #(
        .FIFO_LOGSIZE(LOG), .ADDR_W(AW), .DATA_W(DW), .V_ACTIVE(VA)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .pix_valid(pix_valid),
        .proc_pixs(proc_pixs), .proc_addr(proc_addr), .zbt_grant(zbt_grant),
        .zbt_addr(zbt_addr), .zbt_we(zbt_we), .zbt_write_data(zbt_write_data),
        .fifo_level(fifo_level), .overflow(overflow), .idle(idle)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;
    typedef struct {
        int            due;
        logic [DW-1:0] d;
    } sched_t;

    ent_t          mq[$];
    sched_t        sched[$];
    int            m_mode;
    bit            m_ovf, m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wd;
    int            cyc_n = 0;
    int            checks = 0;
    int            errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s cycle %0d observed=%0h expected=%0h", tag, cyc_n, got, exp);
        end
    endtask

    task automatic tick(input bit rst, input bit en, input bit pv,
                        input logic [DW-1:0] d, input logic [AW-1:0] a, input bit g);
        bit     pop, push_req;
        int     pre_size;
        bit     pre_we;
        ent_t   head;
        sched_t s;
        reset = rst; enable = en; pix_valid = pv; proc_pixs = d; proc_addr = a; zbt_grant = g;
        if (rst) begin
            mq.delete(); sched.delete();
            m_mode = 0; m_ovf = 0; m_we = 0; m_addr = '0; m_wd = '0;
        end else begin
            pre_size = mq.size();
            pre_we   = m_we;
            pop      = g && (pre_size > 0);
            push_req = (m_mode == 1) && pv && (int'(a[AW-1 -: 10]) < VA);
            if (sched.size() > 0 && sched[0].due == cyc_n) begin
                m_wd = sched[0].d;
                void'(sched.pop_front());
            end
            if (pop) begin
                head   = mq.pop_front();
                m_addr = head.a;
                s.due  = cyc_n + 2;
                s.d    = head.d;
                sched.push_back(s);
            end
            m_we = pop;
            if (push_req) begin
                if (mq.size() < 8) mq.push_back({a, d});
                else m_ovf = 1;
            end
            case (m_mode)
                0: if (en) m_mode = 1;
                1: if (!en) m_mode = 2;
                default: begin
                    if (en) m_mode = 1;
                    else if (pre_size == 0 && !pre_we) m_mode = 0;
                end
            endcase
        end
        @(posedge clk); #1;
        cyc_n++;
        check("zbt_we", 64'(zbt_we), 64'(m_we));
        check("zbt_addr", 64'(zbt_addr), 64'(m_addr));
        check("zbt_write_data", 64'(zbt_write_data), 64'(m_wd));
        check("fifo_level", 64'(fifo_level), 64'(mq.size()));
        check("overflow", 64'(overflow), 64'(m_ovf));
        check("idle", 64'(idle), 64'(m_mode == 0));
    endtask

    function automatic logic [DW-1:0] rnd_data();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[DW-1:0];
    endfunction

    function automatic logic [AW-1:0] rnd_addr(input bit in_range);
        logic [9:0] row;
        logic [8:0] col;
        row = in_range ? 10'($urandom_range(0, VA-1)) : 10'($urandom_range(VA, 1023));
        col = 9'($urandom());
        return {row, col};
    endfunction

    task automatic idle_cycles(input int n, input bit en, input bit g);
        for (int i = 0; i < n; i++) tick(0, en, 0, '0, '0, g);
    endtask

    task automatic words(input int n, input bit g);
        for (int i = 0; i < n; i++) begin
            tick(0, 1, 1, rnd_data(), rnd_addr(1), g);
            tick(0, 1, 0, '0, '0, g);
        end
    endtask

    initial begin
        // Reset held with pix_valid toggling.
        for (int i = 0; i < 3; i++) tick(1, 1, i[0], rnd_data(), rnd_addr(1), 1);

        // Single write with known address/data.
        tick(0, 1, 0, '0, '0, 1);
        tick(0, 1, 1, 36'h123456789, 19'h00A05, 1);
        idle_cycles(5, 1, 1);

        // Backlog to full, then drain.
        words(8, 0);
        idle_cycles(12, 1, 1);

        // Overflow, push+pop at full, drain.
        words(9, 0);
        for (int i = 0; i < 4; i++) tick(0, 1, 1, rnd_data(), rnd_addr(1), 1);
        tick(0, 1, 1, rnd_data(), rnd_addr(1), 0);
        idle_cycles(12, 1, 1);

        // Row range boundary with overflow cleared by reset.
        tick(1, 1, 0, '0, '0, 0);
        tick(0, 1, 0, '0, '0, 0);
        tick(0, 1, 1, rnd_data(), 19'h60000, 1);
        tick(0, 1, 1, rnd_data(), 19'h5FFFF, 1);
        tick(0, 1, 1, rnd_data(), rnd_addr(0), 1);
        idle_cycles(5, 1, 1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            tick(0, ($urandom_range(0, 9) != 0), $urandom_range(0, 1),
                 rnd_data(), rnd_addr($urandom_range(0, 5) != 0), $urandom_range(0, 1));
        end
        idle_cycles(12, 1, 1);

        // Flush: queue five, drop enable, drain and return to idle.
        words(5, 0);
        idle_cycles(3, 0, 0);
        idle_cycles(10, 0, 1);

        // Flush interrupted by enable, then reset during a flush.
        tick(0, 1, 0, '0, '0, 0);
        words(5, 0);
        idle_cycles(2, 0, 0);
        idle_cycles(2, 0, 1);
        tick(1, 0, 0, '0, '0, 1);
        idle_cycles(4, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/zbt_proc_writer.md
# zbt_proc_writer

Write-back stage directly downstream of the colour-processing stage. Accepts one processed two-pixel word (36 bits) plus its ZBT address every other cycle, buffers it in a small FIFO, and issues pipelined writes to ZBT bank 1 whenever the bank arbiter grants a slot. Display reads keep priority on the bank, so the FIFO absorbs grant gaps and the block applies ZBT write-data latency (data two cycles after address/WE).

## Interface
- FIFO_LOGSIZE, 3, log2 of FIFO depth (8 entries)
- ADDR_W, 19, ZBT word address width
- DATA_W, 36, two-pixel word width
- V_ACTIVE, 768, rows written; addresses with row field ≥ V_ACTIVE are dropped
- clk  in  1  system pixel clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- enable  in  1  accept new words when high; low starts a flush
- pix_valid  in  1  strobe: proc_pixs/proc_addr valid this cycle
- proc_pixs  in  DATA_W  processed two-pixel word
- proc_addr  in  ADDR_W  target address {row[9:0], col_pair[8:0]}
- zbt_grant  in  1  bank 1 free for a write this cycle
- zbt_addr  out  ADDR_W  registered write address
- zbt_we  out  1  registered write enable, active-high
- zbt_write_data  out  DATA_W  write data, 2 cycles after its zbt_we
- fifo_level  out  FIFO_LOGSIZE+1  current occupancy
- overflow  out  1  sticky: an accepted-range word was lost to a full FIFO
- idle  out  1  high in IDLE state

## Operation
- States: IDLE, RUN, FLUSH. Reset → IDLE.
- IDLE: enable=1 → RUN. No pushes. Pops still allowed (FIFO empty after reset anyway).
- RUN: push when pix_valid && row field (proc_addr[18:9]) < V_ACTIVE. enable=0 → FLUSH.
- FLUSH: no pushes; pops continue; when FIFO empty and no write in flight (zbt_we pipeline empty) → IDLE. enable=1 in FLUSH → RUN directly (no wait).
- Pop: when FIFO non-empty and zbt_grant=1, head is popped; zbt_addr←head address, zbt_we←1. Otherwise zbt_we←0, zbt_addr holds.
- Data pipeline: popped data passes two register stages; zbt_write_data = data popped at edge t, visible from t+3 (zbt_we visible t+1). zbt_write_data holds last value when no write.
- Full FIFO, push with simultaneous pop: accepted, level unchanged. Full FIFO, push without pop: incoming word discarded, overflow←1.
- Out-of-range rows: silently discarded, never set overflow.
- Empty FIFO, push and grant same cycle: no bypass; word written to FIFO, popped at earliest next cycle.
- overflow clears only on reset.
- Level arithmetic: level = level + push − pop, never exceeds 2^FIFO_LOGSIZE, never underflows.

## Timing
- Reset values: zbt_addr=0, zbt_we=0, zbt_write_data=0, fifo_level=0, overflow=0, idle=1; FIFO pointers 0; data pipeline cleared.
- Reset mid-operation: FIFO contents and in-flight writes abandoned; no zbt_we asserted after the reset edge.
- Minimum latency pix_valid(cycle t) → zbt_we high at t+2 (pushed at edge t, popped at edge t+1 with grant), data at t+4.
- Throughput: one write per granted cycle; sustained input of one word per 2 cycles with ≥50% grant never overflows.
- idle and fifo_level are registered, updated same edge as state/pointers.

## Test plan
- Reset: hold reset 3 cycles with pix_valid toggling → all outputs at reset values, idle=1, no zbt_we.
- Single write: enable=1, grant=1, one pix_valid at t with addr 0x00A05, data 0x123456789 → zbt_we=1, zbt_addr=0x00A05 at t+2; zbt_write_data=0x123456789 at t+4 only.
- Backlog: grant=0, 8 words every 2 cycles → level reaches 8, overflow=0; grant=1 → 8 consecutive writes in push order, level to 0.
- Overflow: grant=0, 9 words → 9th dropped, overflow=1 and stays 1; draining writes exactly first 8; push+pop at full keeps level 8, no overflow.
- Range drop: addr row 768 (0x60000) and 767 → only row-767 word written; overflow stays 0.
- Flush: 5 words queued, grant=0, enable→0 → state FLUSH, idle=0; grant=1 → 5 writes, idle=1 two cycles after last zbt_we; reset asserted during flush → zbt_we=0 next cycle, level=0.
